pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter supporting logical left, logical right, arithmetic right and rotate-right on a WIDTH-bit operand. It generalises the single-width, arithmetic-only combinational shifter into a multi-mode unit. The unit has one log-stage per pipeline register and a valid/ready handshake with full backpressure. It sits beside the ALU as the shift execution unit for multi-cycle or pipelined datapaths. A TAG_W sideband travels with each operand.

---
 rtl/shift_pkg.sv | 11 +
 rtl/shift_stage.sv | 63 ++++++
 rtl/pipelined_shifter.sv | 49 ++++
 tb/tb_pipelined_shifter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shift-op encoding and bit-reverse helper shared by the pipelined shifter
package shift_pkg;
  typedef enum logic [1:0] {SLL, SRL, SRA, ROR} shift_op_e;
  localparam int MAX_W = 256;
  function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] d, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) if (i < w) r[i] = d[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one conditional 2^STAGE right shift/rotate with its pipeline register and advance logic
module shift_stage import shift_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int SHAMT_W = 5,
  parameter int STAGE   = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         op_i,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               adv_i,
  output logic               adv_o,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic [1:0]         op_o,
  output logic               fill_o,
  output logic [TAG_W-1:0]   tag_o
);
  localparam int S = 1 << STAGE;
  logic               valid_q, fill_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q;
  logic [1:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  always_comb begin
    data_d = !shamt_i[STAGE] ? data_i :
             op_i == ROR     ? {data_i[S-1:0], data_i[WIDTH-1:S]} :
                               {{S{fill_i}}, data_i[WIDTH-1:S]};
  end
  assign adv_o = !valid_q || adv_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      tag_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (adv_o) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      shamt_q <= shamt_i;
      op_q    <= op_i;
      fill_q  <= fill_i;
      tag_q   <= tag_i;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign op_o    = op_q;
  assign fill_o  = fill_q;
  assign tag_o   = tag_q;
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log2(WIDTH)-stage SLL/SRL/SRA/ROR barrel shifter with valid/ready backpressure
module pipelined_shifter import shift_pkg::*; #(
  parameter  int WIDTH   = 32,
  parameter  int TAG_W   = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_op,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_data,
  output logic [TAG_W-1:0]   o_tag
);
  localparam int L = SHAMT_W;
  logic               v   [0:L];
  logic               adv [0:L];
  logic [WIDTH-1:0]   d   [0:L];
  logic [SHAMT_W-1:0] sh  [0:L];
  logic [1:0]         op  [0:L];
  logic               fl  [0:L];
  logic [TAG_W-1:0]   tg  [0:L];
  // SLL is done as a right shift of the bit-reversed operand
  assign v[0]   = i_valid;
  assign d[0]   = i_op == SLL ? WIDTH'(bit_rev(MAX_W'(i_data), WIDTH)) : i_data;
  assign sh[0]  = i_shamt;
  assign op[0]  = i_op;
  assign fl[0]  = i_op == SRA && i_data[WIDTH-1];
  assign tg[0]  = i_tag;
  assign adv[L] = i_ready;
  for (genvar k = 0; k < L; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .SHAMT_W(SHAMT_W), .STAGE(k)) u_stage (
      .clk_i(i_clk), .rst_ni(i_rst_n), .flush_i(i_flush),
      .valid_i(v[k]), .data_i(d[k]), .shamt_i(sh[k]), .op_i(op[k]), .fill_i(fl[k]), .tag_i(tg[k]),
      .adv_i(adv[k+1]), .adv_o(adv[k]),
      .valid_o(v[k+1]), .data_o(d[k+1]), .shamt_o(sh[k+1]), .op_o(op[k+1]), .fill_o(fl[k+1]), .tag_o(tg[k+1])
    );
  end
  assign o_ready = !i_flush && adv[0];
  assign o_valid = v[L];
  assign o_data  = op[L] == SLL ? WIDTH'(bit_rev(MAX_W'(d[L]), WIDTH)) : d[L];
  assign o_tag   = tg[L];
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: random and directed scoreboard bench for pipelined_shifter at WIDTH 8/32/64
module tb_pipelined_shifter;
  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
    int          c;
    bit          lat;
  } exp_t;

  logic clk = 0, rst_n = 0, flush = 0, nof = 0, rdy1 = 1;
  logic v32 = 0, r32 = 1, or32, ov32;
  logic [31:0] d32 = 0, od32;
  logic [4:0] s32 = 0;
  logic [1:0] op32 = 0;
  logic [3:0] t32 = 0, ot32;
  logic v8 = 0, or8, ov8;
  logic [7:0] d8 = 0, od8;
  logic [2:0] s8 = 0;
  logic [1:0] op8 = 0;
  logic [3:0] t8 = 0, ot8;
  logic v64 = 0, or64, ov64;
  logic [63:0] d64 = 0, od64;
  logic [5:0] s64 = 0;
  logic [1:0] op64 = 0;
  logic [3:0] t64 = 0, ot64;

  exp_t q32[$], q8[$], q64[$];
  int cyc = 0, checks = 0, errors = 0;
  bit lat_on = 0, end_req = 0, done = 0, hold = 0, post_flush = 0, saw_full = 0;
  logic [31:0] hd;
  logic [3:0] ht;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_shifter #(.WIDTH(32), .TAG_W(4)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v32), .o_ready(or32),
    .i_data(d32), .i_shamt(s32), .i_op(op32), .i_tag(t32),
    .o_valid(ov32), .i_ready(r32), .o_data(od32), .o_tag(ot32));
  pipelined_shifter #(.WIDTH(8), .TAG_W(4)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(nof), .i_valid(v8), .o_ready(or8),
    .i_data(d8), .i_shamt(s8), .i_op(op8), .i_tag(t8),
    .o_valid(ov8), .i_ready(rdy1), .o_data(od8), .o_tag(ot8));
  pipelined_shifter #(.WIDTH(64), .TAG_W(4)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(nof), .i_valid(v64), .o_ready(or64),
    .i_data(d64), .i_shamt(s64), .i_op(op64), .i_tag(t64),
    .o_valid(ov64), .i_ready(rdy1), .o_data(od64), .o_tag(ot64));

  // Reference: plain arithmetic on a w-bit value held in 64 bits
  function automatic logic [63:0] ref_shift(input int w, input logic [1:0] o, input logic [63:0] din, input int s);
    logic [63:0] m, x, r;
    m = w == 64 ? '1 : (64'd1 << w) - 64'd1;
    x = din & m;
    case (o)
      2'd0:    r = (x << s) & m;
      2'd1:    r = x >> s;
      2'd2:    r = (x >> s) | (x[w-1] ? m & ~(m >> s) : 64'd0);
      default: r = ((x >> s) | (x << (w - s))) & m;
    endcase
    return r;
  endfunction

  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endfunction

  function automatic void take(input int w, input logic [63:0] od, input logic [3:0] ot);
    exp_t e;
    int sz;
    sz = w == 8 ? q8.size() : w == 32 ? q32.size() : q64.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL out%0d_unexpected: got result tag %0h data %0h, expected no result", w, ot, od);
      return;
    end
    if (w == 8) e = q8.pop_front();
    else if (w == 32) e = q32.pop_front();
    else e = q64.pop_front();
    chk($sformatf("data_w%0d_tag%0h", w, e.t), od, e.d);
    chk($sformatf("tag_w%0d", w), 64'(ot), 64'(e.t));
    if (e.lat) chk($sformatf("latency_w%0d", w), 64'(cyc - e.c), 64'($clog2(w)));
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_o_valid", 64'(ov32), 64'd0);
      chk("rst_o_data", 64'(od32), 64'd0);
      chk("rst_o_tag", 64'(ot32), 64'd0);
      chk("rst_o_ready", 64'(or32), 64'd1);
      q32.delete();
      q8.delete();
      q64.delete();
      hold = 0;
      post_flush = 0;
    end else begin
      if (ov32 && hold) begin
        chk("hold_o_data", 64'(od32), 64'(hd));
        chk("hold_o_tag", 64'(ot32), 64'(ht));
      end
      if (ov32 && r32) take(32, 64'(od32), ot32);
      hold = ov32 && !r32;
      hd = od32;
      ht = ot32;
      if (ov8) take(8, 64'(od8), ot8);
      if (ov64) take(64, od64, ot64);
      if (flush) begin
        chk("flush_o_ready", 64'(or32), 64'd0);
        q32.delete();
      end
      if (post_flush) chk("post_flush_o_ready", 64'(or32), 64'd1);
      post_flush = flush;
      if (v32 && !or32 && !flush) saw_full = 1;
      if (v32 && or32) q32.push_back('{d: ref_shift(32, op32, 64'(d32), int'(s32)), t: t32, c: cyc, lat: lat_on});
      if (v8 && or8) q8.push_back('{d: ref_shift(8, op8, 64'(d8), int'(s8)), t: t8, c: cyc, lat: 1'b1});
      if (v64 && or64) q64.push_back('{d: ref_shift(64, op64, d64, int'(s64)), t: t64, c: cyc, lat: 1'b1});
    end
    if (end_req && !done) begin
      chk("q32_drained", 64'(q32.size()), 64'd0);
      chk("q8_drained", 64'(q8.size()), 64'd0);
      chk("q64_drained", 64'(q64.size()), 64'd0);
      chk("o_ready_dropped_when_full", 64'(saw_full), 64'd1);
      done = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s, input logic [3:0] t);
    bit ok;
    ok = 0;
    v32 = 1; op32 = o; d32 = d; s32 = s; t32 = t;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = or32;
    end
    if (!ok) begin
      $display("FAIL send32_timeout: o_ready low for 64 cycles, expected an accept");
      $fatal(1, "input never accepted");
    end
    @(posedge clk);
    #1;
    v32 = 0;
  endtask

  initial begin
    bit stop;
    stop = 0;
    idle(3);
    rst_n = 1;
    idle(1);
    lat_on = 1;
    for (int o = 0; o < 4; o++) send32(2'(o), 32'h8000_00F1, 5'd4, 4'(o));
    for (int o = 0; o < 4; o++) send32(2'(o), 32'hA5C3_0F96, 5'd0, 4'(4 + o));
    send32(2'd2, 32'h8000_0000, 5'd31, 4'd8);
    send32(2'd0, 32'h0000_0001, 5'd31, 4'd9);
    send32(2'd1, 32'h8000_0000, 5'd31, 4'd10);
    send32(2'd3, 32'h0000_0001, 5'd1, 4'd11);
    idle(8);
    lat_on = 0;
    fork
      for (int i = 0; i < 8; i++) send32(2'($urandom), $urandom, 5'($urandom), 4'(i));
      begin
        repeat (5) @(posedge clk);
        #1 r32 = 0;
        repeat (3) @(posedge clk);
        #1 r32 = 1;
      end
    join
    idle(12);
    lat_on = 1;
    for (int i = 0; i < 3; i++) send32(2'($urandom), $urandom, 5'($urandom), 4'(12 + i));
    v32 = 1; flush = 1; d32 = $urandom; t32 = 4'hF;
    idle(1);
    v32 = 0; flush = 0;
    idle(10);
    for (int i = 0; i < 4; i++) send32(2'($urandom), $urandom, 5'($urandom), 4'(i));
    #2 rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(10);
    lat_on = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) send32(2'($urandom), $urandom, 5'($urandom), 4'($urandom));
        stop = 1;
      end
      while (!stop) begin
        @(posedge clk);
        #1 r32 = $urandom_range(0, 3) != 0;
      end
    join
    r32 = 1;
    idle(12);
    for (int i = 0; i < 60; i++) begin
      v8 = 1; d8 = 8'($urandom); s8 = 3'($urandom); op8 = 2'($urandom); t8 = 4'($urandom);
      v64 = 1; d64 = {$urandom, $urandom}; s64 = 6'($urandom); op64 = 2'($urandom); t64 = 4'($urandom);
      idle(1);
    end
    v8 = 0; v64 = 0;
    idle(10);
    end_req = 1;
    for (int i = 0; i < 5 && !done; i++) @(posedge clk);
    if (!done) begin
      $display("FAIL end_checks: final checks not reached, expected within 5 cycles");
      $fatal(1, "monitor stalled");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
